spi_regfile_periph: RTL and testbench



---
 rtl/spi_regfile_pkg.sv | 22 ++
 rtl/spi_sync_edge.sv | 31 +++
 rtl/spi_regfile_periph.sv | 190 +++++++++++++++++++
 tb/tb_spi_regfile_periph.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_regfile_pkg.sv
// Shared types and helpers for the SPI register-file peripheral.
package spi_regfile_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
        return 1 + addr_w + data_w;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned fw);
        return $clog2(fw + 1);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with a history flop; edges compare the two settled stages.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
            s3 <= RST_VAL;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level  = s2;
    assign rise_c = s2 & ~s3;
    assign fall_c = ~s2 & s3;

endmodule

// File: rtl/spi_regfile_periph.sv
// SPI mode-0 peripheral fronting a NUM_REGS x DATA_W register file.
// Define SPI_REGFILE_AUTOINC_EN for burst mode with wrapping address auto-increment.
module spi_regfile_periph
    import spi_regfile_pkg::*;
#(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       ADDR_W    = 7,
    parameter int unsigned       NUM_REGS  = 5,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       nCS,
    input  logic                       SCLK,
    input  logic                       COPI,
    output logic                       CIPO,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr
);

    localparam int unsigned FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int unsigned CNT_W   = cnt_w(FRAME_W);
    localparam int unsigned SH_W    = ((1 + ADDR_W) > DATA_W) ? (1 + ADDR_W) : DATA_W;

    logic ncs_level, ncs_rise_c, ncs_fall_c;
    logic sclk_level, sclk_rise_c, sclk_fall_c;
    logic copi_level, copi_rise_c, copi_fall_c;

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst(rst), .d(nCS),
        .level(ncs_level), .rise_c(ncs_rise_c), .fall_c(ncs_fall_c)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(SCLK),
        .level(sclk_level), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .d(COPI),
        .level(copi_level), .rise_c(copi_rise_c), .fall_c(copi_fall_c)
    );

    logic unused_sync;
    assign unused_sync = &{1'b0, ncs_level, sclk_level, copi_rise_c, copi_fall_c};

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [SH_W-2:0]            shreg_q, shreg_d;
    logic [SH_W-1:0]            sh_next;
    logic                       rw_q, rw_d;
    logic [ADDR_W-1:0]          addr_q, addr_d, rd_addr;
    logic [DATA_W-1:0]          txreg_q, txreg_d, rd_data;
    logic                       cipo_d, oe_d, wr_strobe_d, wr_en_c;
    logic [ADDR_W-1:0]          wr_addr_d;
    logic [NUM_REGS*DATA_W-1:0] regs_q;

    function automatic logic is_mapped(input logic [ADDR_W-1:0] a);
        return 32'(a) < NUM_REGS;
    endfunction

    assign sh_next = {shreg_q, copi_level};

`ifdef SPI_REGFILE_AUTOINC_EN
    logic [ADDR_W-1:0] addr_inc;
    assign addr_inc = (32'(addr_q) == NUM_REGS - 1) ? '0 : addr_q + ADDR_W'(1);
    assign rd_addr  = (state_q == ST_DATA) ? addr_inc : sh_next[ADDR_W-1:0];
`else
    assign rd_addr  = sh_next[ADDR_W-1:0];
`endif

    // Read mux; unmapped addresses return zero.
    always_comb begin
        rd_data = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (rd_addr == ADDR_W'(k)) rd_data = regs_q[k*DATA_W +: DATA_W];
        end
    end

    // Next-state and datapath decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        txreg_d     = txreg_q;
        cipo_d      = CIPO;
        oe_d        = cipo_oe;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr;
        wr_en_c     = 1'b0;

        if (ncs_fall_c) begin
            state_d = ST_CMD;
            cnt_d   = '0;
            shreg_d = '0;
            oe_d    = 1'b0;
            cipo_d  = 1'b0;
        end else begin
            case (state_q)
                ST_CMD: begin
                    if (sclk_rise_c) begin
                        shreg_d = sh_next[SH_W-2:0];
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(ADDR_W)) begin
                            rw_d    = sh_next[ADDR_W];
                            addr_d  = sh_next[ADDR_W-1:0];
                            cnt_d   = '0;
                            state_d = ST_DATA;
                            if (sh_next[ADDR_W] == RW_READ) begin
                                txreg_d = rd_data;
                                cipo_d  = rd_data[DATA_W-1];
                                oe_d    = 1'b1;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (sclk_rise_c) begin
                        shreg_d = sh_next[SH_W-2:0];
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            cnt_d = '0;
                            if (rw_q == RW_WRITE && is_mapped(addr_q)) begin
                                wr_en_c     = 1'b1;
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = addr_q;
                            end
`ifdef SPI_REGFILE_AUTOINC_EN
                            addr_d = addr_inc;
                            if (rw_q == RW_READ) begin
                                txreg_d = rd_data;
                                cipo_d  = rd_data[DATA_W-1];
                            end
`else
                            state_d = ST_HOLD;
`endif
                        end
                    end else if (sclk_fall_c && rw_q == RW_READ && cnt_q != '0) begin
                        // The fall right after a (re)load is skipped so the MSB survives to the next rise.
                        txreg_d = txreg_q << 1;
                        cipo_d  = txreg_q[DATA_W-2];
                    end
                end
                default: ;
            endcase

            if (ncs_rise_c && state_q != ST_IDLE) begin
                state_d = ST_IDLE;
                oe_d    = 1'b0;
                cipo_d  = 1'b0;
            end
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            txreg_q   <= '0;
            CIPO      <= 1'b0;
            cipo_oe   <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            regs_q    <= {NUM_REGS{RESET_VAL}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            txreg_q   <= txreg_d;
            CIPO      <= cipo_d;
            cipo_oe   <= oe_d;
            wr_strobe <= wr_strobe_d;
            wr_addr   <= wr_addr_d;
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (wr_en_c && addr_q == ADDR_W'(k)) regs_q[k*DATA_W +: DATA_W] <= sh_next[DATA_W-1:0];
            end
        end
    end

    assign regs_out = regs_q;

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Directed bench for spi_regfile_periph; expectations for burst follow SPI_REGFILE_AUTOINC_EN.
module tb_spi_regfile_periph;
    import spi_regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nCS = 1'b1;
    logic        SCLK = 1'b0;
    logic        COPI = 1'b0;
    logic        CIPO;
    logic        cipo_oe;
    logic [39:0] regs_out;
    logic        wr_strobe;
    logic [6:0]  wr_addr;

    spi_regfile_periph dut (
        .clk(clk), .rst(rst), .nCS(nCS), .SCLK(SCLK), .COPI(COPI),
        .CIPO(CIPO), .cipo_oe(cipo_oe), .regs_out(regs_out),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int         strobe_pulses = 0;
    int         strobe_hi = 0;
    logic       strobe_prev = 1'b0;
    logic [6:0] strobe_addr = '0;

    always @(negedge clk) begin
        strobe_prev <= wr_strobe;
        if (wr_strobe === 1'b1) begin
            strobe_hi   <= strobe_hi + 1;
            strobe_addr <= wr_addr;
            if (strobe_prev !== 1'b1) strobe_pulses <= strobe_pulses + 1;
        end
    end

    typedef struct {
        logic [31:0] bits;
        int          nbits;
        logic        rd;
        logic [39:0] exp_regs;
        int          exp_strobes;
        logic [6:0]  exp_wr_addr;
        logic [7:0]  exp_rx;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, output logic sampled);
        COPI = b;
        tick(5);
        sampled = CIPO;
        SCLK = 1'b1;
        tick(5);
        SCLK = 1'b0;
    endtask

    task automatic xfer(input logic [31:0] bits, input int nbits, output logic [7:0] rx);
        logic s;
        rx = '0;
        nCS = 1'b0;
        tick(6);
        for (int i = 0; i < nbits; i++) begin
            send_bit(bits[nbits-1-i], s);
            if (i >= 8 && i < 16) rx[15-i] = s;
        end
        tick(5);
        nCS = 1'b1;
        COPI = 1'b0;
        tick(12);
    endtask

    initial begin
        logic [7:0] rx;
        logic       s;
        int         p0, h0;
        logic [15:0] word;

        vecs[0] = '{32'h82A5, 16, 1'b0, 40'h00_00_A5_00_00, 1, 7'd2, 8'h00};
        vecs[1] = '{32'h0200, 16, 1'b1, 40'h00_00_A5_00_00, 0, 7'd2, 8'hA5};
        vecs[2] = '{32'h0211, 10, 1'b0, 40'h00_00_A5_00_00, 0, 7'd2, 8'h00};
        vecs[3] = '{32'h90FF, 16, 1'b0, 40'h00_00_A5_00_00, 0, 7'd2, 8'h00};
        vecs[4] = '{32'h1000, 16, 1'b1, 40'h00_00_A5_00_00, 0, 7'd2, 8'h00};
        vecs[5] = '{32'h84C3, 16, 1'b0, 40'hC3_00_A5_00_00, 1, 7'd4, 8'h00};
        vecs[6] = '{32'h0400, 16, 1'b1, 40'hC3_00_A5_00_00, 0, 7'd4, 8'hC3};
        vecs[7] = '{32'h805A, 16, 1'b0, 40'hC3_00_A5_00_5A, 1, 7'd0, 8'h00};
        vecs[8] = '{32'h0000, 16, 1'b1, 40'hC3_00_A5_00_5A, 0, 7'd0, 8'h5A};

        tick(4);
        check("reset_regs", 64'(regs_out), 64'h0);
        check("reset_cipo", 64'(CIPO), 64'h0);
        check("reset_oe", 64'(cipo_oe), 64'h0);
        check("reset_strobe", 64'(wr_strobe), 64'h0);
        check("reset_wr_addr", 64'(wr_addr), 64'h0);
        rst = 1'b0;
        tick(4);

        for (int i = 0; i < 9; i++) begin
            p0 = strobe_pulses;
            h0 = strobe_hi;
            xfer(vecs[i].bits, vecs[i].nbits, rx);
            check($sformatf("v%0d_regs", i), 64'(regs_out), 64'(vecs[i].exp_regs));
            check($sformatf("v%0d_strobes", i), 64'(strobe_pulses - p0), 64'(vecs[i].exp_strobes));
            check($sformatf("v%0d_strobe_width", i), 64'(strobe_hi - h0), 64'(vecs[i].exp_strobes));
            check($sformatf("v%0d_wr_addr", i), 64'(wr_addr), 64'(vecs[i].exp_wr_addr));
            check($sformatf("v%0d_idle", i), 64'(dut.state_q), 64'(ST_IDLE));
            check($sformatf("v%0d_oe_off", i), 64'(cipo_oe), 64'h0);
            if (vecs[i].exp_strobes != 0)
                check($sformatf("v%0d_strobe_addr", i), 64'(strobe_addr), 64'(vecs[i].exp_wr_addr));
            if (vecs[i].rd)
                check($sformatf("v%0d_rx", i), 64'(rx), 64'(vecs[i].exp_rx));
        end

        // Output-enable window on a read of reg2.
        word = 16'h0200;
        nCS = 1'b0;
        tick(6);
        for (int i = 0; i < 7; i++) send_bit(word[15-i], s);
        check("oe_before_addr", 64'(cipo_oe), 64'h0);
        send_bit(word[8], s);
        check("oe_after_addr", 64'(cipo_oe), 64'h1);
        check("cipo_msb", 64'(CIPO), 64'h1);
        for (int i = 8; i < 16; i++) send_bit(word[15-i], s);
        tick(5);
        nCS = 1'b1;
        tick(2);
        check("oe_2clk_after_ncs", 64'(cipo_oe), 64'h1);
        tick(1);
        check("oe_3clk_after_ncs", 64'(cipo_oe), 64'h0);
        tick(10);

        // Reset in the middle of a frame.
        word = 16'h8155;
        nCS = 1'b0;
        tick(6);
        for (int i = 0; i < 5; i++) send_bit(word[15-i], s);
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_regs", 64'(regs_out), 64'h0);
        check("midrst_oe", 64'(cipo_oe), 64'h0);
        check("midrst_wr_addr", 64'(wr_addr), 64'h0);
        nCS = 1'b1;
        COPI = 1'b0;
        tick(12);
        p0 = strobe_pulses;
        xfer(32'h8133, 16, rx);
        check("after_rst_regs", 64'(regs_out), 64'h00_00_00_33_00);
        check("after_rst_strobes", 64'(strobe_pulses - p0), 64'd1);

        // nCS rise in the same clk as the final SCLK rise still commits.
        word = 16'h8177;
        p0 = strobe_pulses;
        nCS = 1'b0;
        tick(6);
        for (int i = 0; i < 15; i++) send_bit(word[15-i], s);
        COPI = word[0];
        tick(5);
        SCLK = 1'b1;
        nCS = 1'b1;
        tick(5);
        SCLK = 1'b0;
        COPI = 1'b0;
        tick(12);
        check("simul_regs", 64'(regs_out), 64'h00_00_00_77_00);
        check("simul_strobes", 64'(strobe_pulses - p0), 64'd1);
        check("simul_wr_addr", 64'(wr_addr), 64'd1);
        check("simul_idle", 64'(dut.state_q), 64'(ST_IDLE));

        // Burst frame: write reg3 then continue past the first word.
        p0 = strobe_pulses;
        xfer(32'h83112244, 32, rx);
`ifdef SPI_REGFILE_AUTOINC_EN
        check("burst_regs", 64'(regs_out), 64'h22_11_00_77_44);
        check("burst_strobes", 64'(strobe_pulses - p0), 64'd3);
        check("burst_wr_addr", 64'(wr_addr), 64'd0);
`else
        check("burst_regs", 64'(regs_out), 64'h00_11_00_77_00);
        check("burst_strobes", 64'(strobe_pulses - p0), 64'd1);
        check("burst_wr_addr", 64'(wr_addr), 64'd3);
`endif
        check("burst_oe_off", 64'(cipo_oe), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
